ext_interrupt_controller: RTL and testbench

External interrupt controller (EIC) that sits directly upstream of the core interrupt unit.
- Collects NUM_SRC external interrupt lines and latches their rising edges as pending bits.
- Arbitrates among pending, enabled sources by fixed priority.
- Presents one request at a time on EIC_I_Req/EIC_I_Id and retires it when the core toggles EIC_I_Ack.
- Guarantees a minimum low gap on EIC_I_Req between requests so the core's synchronizer and edge detector see every new request.

---
 rtl/ext_interrupt_controller_pkg.sv | 21 ++
 rtl/irq_priority_encoder.sv | 30 +++
 rtl/synchronizer.sv | 30 +++
 rtl/ext_interrupt_controller.sv | 156 +++++++++++++++
 tb/tb_ext_interrupt_controller.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_interrupt_controller_pkg.sv
// ext_interrupt_controller_pkg
// Shared constants and types for the external interrupt controller:
//   TRUE/FALSE     single-bit logic constants
//   Def*           default parameter values for the controller
//   eic_state_e    request FSM encoding (idle / request / low-gap)
package ext_interrupt_controller_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned DefNumSrc    = 2;
    localparam int unsigned DefIdWidth   = 1;
    localparam int unsigned DefGapCycles = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StGap  = 2'b10
    } eic_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder
// Combinational fixed-priority encoder: the lowest set bit wins.
// Ports:
//   req_i    candidate vector (pending & enable)
//   valid_o  at least one bit of req_i is set
//   idx_o    index of the lowest set bit, 0 when valid_o is low
module irq_priority_encoder
    import ext_interrupt_controller_pkg::*;
#(
    parameter int unsigned NumSrc  = DefNumSrc,
    parameter int unsigned IdWidth = DefIdWidth
) (
    input  logic [NumSrc-1:0]  req_i,
    output logic               valid_o,
    output logic [IdWidth-1:0] idx_o
);

    // Scan from the top down so the last hit, the lowest index, is what remains.
    always_comb begin
        valid_o = FALSE;
        idx_o   = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = TRUE;
                idx_o   = IdWidth'(i);
            end
        end
    end

endmodule

// File: rtl/synchronizer.sv
// synchronizer
// Two-flop synchronizer for one asynchronous single-bit input.
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset (both flops clear to 0)
//   d_i     asynchronous input
//   q_o     synchronized output, two clk_i edges of latency
module synchronizer (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ext_interrupt_controller.sv
// ext_interrupt_controller
// Latches rising edges of external interrupt lines as pending bits, presents the
// highest-priority (lowest index) enabled one to the core as a level request, retires
// it on an acknowledge toggle and then holds the request low for a guaranteed gap.
// Ports:
//   Sys_Clock    system clock, all state on the rising edge
//   Sys_Reset    asynchronous active-low reset
//   Irq_Src      raw asynchronous interrupt lines, rising edge significant
//   Irq_Enable   per-source enable, synchronous
//   EIC_I_Req    registered request level to the core
//   EIC_I_Id     registered index of the requested source, 0 while idle
//   EIC_I_Ack    asynchronous toggle acknowledge from the core
//   EIC_Pending  pending status bits
module ext_interrupt_controller
    import ext_interrupt_controller_pkg::*;
#(
    parameter int unsigned NUM_SRC    = DefNumSrc,
    parameter int unsigned ID_WIDTH   = DefIdWidth,
    parameter int unsigned GAP_CYCLES = DefGapCycles
) (
    input  logic                Sys_Clock,
    input  logic                Sys_Reset,
    input  logic [NUM_SRC-1:0]  Irq_Src,
    input  logic [NUM_SRC-1:0]  Irq_Enable,
    output logic                EIC_I_Req,
    output logic [ID_WIDTH-1:0] EIC_I_Id,
    input  logic                EIC_I_Ack,
    output logic [NUM_SRC-1:0]  EIC_Pending
);

    // Counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int unsigned GapW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    logic [NUM_SRC-1:0]  src_sync;
    logic [NUM_SRC-1:0]  src_last_q;
    logic [NUM_SRC-1:0]  src_rise;
    logic                ack_sync;
    logic                ack_last_q;
    logic                ack_event;

    logic [NUM_SRC-1:0]  pending_q;
    logic [NUM_SRC-1:0]  pending_d;
    logic [NUM_SRC-1:0]  clr_mask;
    logic [NUM_SRC-1:0]  eligible;
    logic                win_valid;
    logic [ID_WIDTH-1:0] win_idx;

    eic_state_e          state_q;
    logic                req_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [GapW-1:0]     gap_q;
    logic                retire;

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src_sync
        synchronizer u_src_sync (
            .clk_i  (Sys_Clock),
            .rst_ni (Sys_Reset),
            .d_i    (Irq_Src[g]),
            .q_o    (src_sync[g])
        );
    end

    synchronizer u_ack_sync (
        .clk_i  (Sys_Clock),
        .rst_ni (Sys_Reset),
        .d_i    (EIC_I_Ack),
        .q_o    (ack_sync)
    );

    // Last-value registers for edge detection. ack_last resets to 0 to match the
    // core's reset value of its toggle output, so reset never looks like an ack.
    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            src_last_q <= '0;
            ack_last_q <= FALSE;
        end else begin
            src_last_q <= src_sync;
            ack_last_q <= ack_sync;
        end
    end

    assign src_rise  = src_sync & ~src_last_q;
    assign ack_event = ack_sync ^ ack_last_q;

    // Acks outside the request state are spurious and only refresh ack_last.
    assign retire   = (state_q == StReq) && ack_event;
    assign clr_mask = retire ? (NUM_SRC'(1) << id_q) : '0;

    // A new edge on the retiring source in the same cycle keeps its bit set.
    assign pending_d = (pending_q & ~clr_mask) | src_rise;

    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign eligible = pending_q & Irq_Enable;

    irq_priority_encoder #(
        .NumSrc  (NUM_SRC),
        .IdWidth (ID_WIDTH)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            state_q <= StIdle;
            req_q   <= FALSE;
            id_q    <= '0;
            gap_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        req_q   <= TRUE;
                        id_q    <= win_idx;
                        state_q <= StReq;
                    end
                end
                // Id stays frozen; pending or enable changes never preempt.
                StReq: begin
                    if (ack_event) begin
                        req_q   <= FALSE;
                        id_q    <= '0;
                        gap_q   <= GapW'(GAP_CYCLES - 1);
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (gap_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - GapW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= FALSE;
                    id_q    <= '0;
                    gap_q   <= '0;
                end
            endcase
        end
    end

    assign EIC_I_Req   = req_q;
    assign EIC_I_Id    = id_q;
    assign EIC_Pending = pending_q;

endmodule

// File: tb/tb_ext_interrupt_controller.sv
`timescale 1ns/1ps
module tb_ext_interrupt_controller;

    localparam int unsigned NS  = 2;
    localparam int unsigned IW  = 1;
    localparam int unsigned GAP = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] src   = '0;
    logic [NS-1:0] en    = '0;
    logic          ack   = 1'b0;
    logic          req;
    logic [IW-1:0] id;
    logic [NS-1:0] pend;

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    always #5 clk = ~clk;

    ext_interrupt_controller #(
        .NUM_SRC    (NS),
        .ID_WIDTH   (IW),
        .GAP_CYCLES (GAP)
    ) dut (
        .Sys_Clock   (clk),
        .Sys_Reset   (rst_n),
        .Irq_Src     (src),
        .Irq_Enable  (en),
        .EIC_I_Req   (req),
        .EIC_I_Id    (id),
        .EIC_I_Ack   (ack),
        .EIC_Pending (pend)
    );

    // Reference model. Inputs are sampled at every active edge; a level sampled at
    // edge n is acted on at edge n+2 (two sync stages), so an event at edge n depends
    // on the samples taken at n-2 and n-3. After a retire at edge r the request may
    // rise no earlier than edge r+GAP+1.
    logic [NS-1:0] m_s1, m_s2, m_s3;
    logic          m_a1, m_a2, m_a3;
    logic [NS-1:0] m_pend;
    bit            m_busy;
    int            m_id;
    longint        m_edge;
    longint        m_earliest;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_s3 = '0;
        m_a1 = 1'b0; m_a2 = 1'b0; m_a3 = 1'b0;
        m_pend = '0; m_busy = 0; m_id = 0;
        m_edge = 0; m_earliest = 0;
    endtask

    task automatic model_step(input logic [NS-1:0] s, input logic [NS-1:0] e, input logic a);
        logic [NS-1:0] rise;
        logic [NS-1:0] elig;
        logic          ack_ev;
        m_edge++;
        rise   = m_s2 & ~m_s3;
        ack_ev = (m_a2 != m_a3);
        elig   = m_pend & e;
        if (m_busy) begin
            if (ack_ev) begin
                m_pend[m_id] = 1'b0;
                m_busy       = 0;
                m_id         = 0;
                m_earliest   = m_edge + GAP + 1;
            end
        end else if (m_edge >= m_earliest && elig != '0) begin
            for (int i = 0; i < NS; i++) begin
                if (elig[i]) begin
                    m_id = i;
                    break;
                end
            end
            m_busy = 1;
        end
        m_pend = m_pend | rise;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = s;
        m_a3 = m_a2; m_a2 = m_a1; m_a1 = a;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (req !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (req !== 1'b1) begin
            bad++;
            $display("FAIL %s: got req=%b want 1 within 50 cycles", name, req);
        end
    endtask

    // Compare process: one model step and full output check per active edge.
    initial begin
        logic [NS-1:0] s_smp, e_smp;
        logic          a_smp, r_smp;
        model_reset();
        while (!done) begin
            @(posedge clk);
            s_smp = src; e_smp = en; a_smp = ack; r_smp = rst_n;
            #1;
            if (!r_smp) model_reset();
            else model_step(s_smp, e_smp, a_smp);
            check("model_req", {31'b0, req}, {31'b0, m_busy});
            check("model_id", 32'(id), m_busy ? 32'(m_id) : 32'd0);
            check("model_pend", 32'(pend), 32'(m_pend));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        en = 2'b11;
        #2;
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_id", 32'(id), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single source: pending at k+2, request at k+3, retire at a+2, gap after.
        repeat (5) @(negedge clk);
        src = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("s1_pend_k2", 32'(pend), 32'h2);
        check("s1_req_k2", {31'b0, req}, 32'd0);
        @(posedge clk);
        #1;
        check("s1_req_k3", {31'b0, req}, 32'd1);
        check("s1_id_k3", 32'(id), 32'd1);
        @(negedge clk);
        src = 2'b00;
        repeat (5) @(negedge clk);
        ack = ~ack;
        repeat (3) @(posedge clk);
        #1;
        check("s1_req_retire", {31'b0, req}, 32'd0);
        check("s1_pend_retire", 32'(pend), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("s1_gap_low", {31'b0, req}, 32'd0);
        end

        // Simultaneous sources: index 0 first, then index 1 after the gap.
        repeat (10) @(negedge clk);
        src = 2'b11;
        wait_req("s2_first");
        check("s2_first_id", 32'(id), 32'd0);
        @(negedge clk);
        src = 2'b00;
        ack = ~ack;
        repeat (4) @(negedge clk);
        wait_req("s2_second");
        check("s2_second_id", 32'(id), 32'd1);
        @(negedge clk);
        ack = ~ack;

        // Masked source stays pending and is served one cycle after enabling.
        repeat (12) @(negedge clk);
        en  = 2'b01;
        src = 2'b10;
        repeat (6) @(negedge clk);
        check("s3_masked_req", {31'b0, req}, 32'd0);
        check("s3_masked_pend", 32'(pend), 32'h2);
        en = 2'b11;
        @(posedge clk);
        #1;
        check("s3_enabled_req", {31'b0, req}, 32'd1);
        check("s3_enabled_id", 32'(id), 32'd1);
        @(negedge clk);
        src = 2'b00;
        ack = ~ack;

        // New edge on the served source lands on the retire edge: set wins.
        repeat (12) @(negedge clk);
        src = 2'b01;
        wait_req("s4_first");
        @(negedge clk);
        src = 2'b00;
        repeat (2) @(negedge clk);
        src = 2'b01;
        ack = ~ack;
        repeat (3) @(posedge clk);
        #1;
        check("s4_pend_kept", 32'(pend), 32'h1);
        check("s4_req_low", {31'b0, req}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("s4_again_req", {31'b0, req}, 32'd1);
        check("s4_again_id", 32'(id), 32'd0);
        @(negedge clk);
        src = 2'b00;
        ack = ~ack;

        // Spurious ack while idle, then a real request still retires normally.
        repeat (12) @(negedge clk);
        ack = ~ack;
        repeat (6) @(negedge clk);
        check("s5_idle_req", {31'b0, req}, 32'd0);
        check("s5_idle_pend", 32'(pend), 32'd0);
        src = 2'b10;
        wait_req("s5_real");
        @(negedge clk);
        ack = ~ack;
        src = 2'b00;
        repeat (4) @(negedge clk);
        check("s5_retired", {31'b0, req}, 32'd0);

        // Randomized traffic with a core that toggles ack at random delays.
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
            end
            if ($urandom_range(0, 49) == 0) en = NS'($urandom);
            if (req) begin
                if ($urandom_range(0, 3) == 0) ack = ~ack;
            end else if ($urandom_range(0, 39) == 0) begin
                ack = ~ack;
            end
        end
        @(negedge clk);
        src = 2'b00;
        en  = 2'b11;
        if (req) ack = ~ack;
        repeat (20) @(negedge clk);
        if (req) ack = ~ack;
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a request.
        src = 2'b01;
        wait_req("s6_before_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ack   = 1'b0;
        #1;
        check("s6_rst_req", {31'b0, req}, 32'd0);
        check("s6_rst_id", 32'(id), 32'd0);
        check("s6_rst_pend", 32'(pend), 32'd0);
        repeat (2) @(negedge clk);
        src   = 2'b00;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        src = 2'b10;
        wait_req("s6_after_reset");
        check("s6_after_id", 32'(id), 32'd1);
        @(negedge clk);
        ack = ~ack;
        src = 2'b00;
        repeat (10) @(negedge clk);

        done = 1;
        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
